// File: rtl/fetch_mem_unit_if.sv
// Memory handshake bundle between the fetch/memory unit (master) and the memory (slave).
interface fetch_mem_unit_if;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/fetch_mem_unit.sv
// Multicycle datapath front end: PC/IR/MDR, memory address select, memory handshake with
// stall, timeout and alignment checking.
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PCWrite,
    input  logic                    PCWriteCond,
    input  logic                    Zero,
    input  logic [1:0]              PCSource,
    input  logic                    IorD,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic                    IRWrite,
    input  logic [31:0]             ALUResult,
    input  logic [31:0]             ALUOut,
    input  logic [31:0]             B,
    fetch_mem_unit_if.master        mem,
    output logic [31:0]             pc,
    output logic [31:0]             ir,
    output logic [4:0]              Op,
    output logic [31:0]             mdr,
    output logic                    stall,
    output logic                    align_err,
    output logic                    bus_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              align_err_q, align_err_d;
    logic              bus_err_q, bus_err_d;

    logic [31:0]       addr;
    logic              access;
    logic              misaligned;
    logic              req;
    logic              abort;
    logic              read_done;
    logic              pc_we;
    logic [31:0]       next_pc;

    assign addr       = IorD ? ALUOut : pc_q;
    assign access     = MemRead | MemWrite;
    assign misaligned = access & (addr[1:0] != 2'b00);
    assign req        = access & ~misaligned & ~align_err_q & ~bus_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req && !mem.mem_ready) begin
                    state_d = StWait;
                    cnt_d   = CntW'(1);
                end
            end
            StWait: begin
                if (!req || mem.mem_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // The timeout cycle releases Control even though the access never completed.
    assign stall     = req & ~mem.mem_ready & ~abort;
    assign read_done = req & MemRead & mem.mem_ready;

    assign mem.mem_addr  = addr;
    assign mem.mem_rd    = req & MemRead;
    assign mem.mem_wr    = req & MemWrite & ~MemRead;
    assign mem.mem_wdata = B;

    assign pc_we = (PCWrite | (PCWriteCond & Zero)) & ~stall & ~abort & (PCSource != 2'b11);

    always_comb begin
        next_pc = pc_q;
        case (PCSource)
            2'b00:   next_pc = ALUResult;
            2'b01:   next_pc = ALUOut;
            2'b10:   next_pc = {pc_q[31:29], ir_q[26:0], 2'b00};
            default: next_pc = pc_q;
        endcase
    end

    always_comb begin
        pc_d        = pc_we ? next_pc : pc_q;
        ir_d        = (read_done && IRWrite) ? mem.mem_rdata : ir_q;
        mdr_d       = read_done ? mem.mem_rdata : mdr_q;
        align_err_d = align_err_q | misaligned;
        bus_err_d   = bus_err_q | abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            mdr_q       <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign Op        = ir_q[31:27];
    assign mdr       = mdr_q;
    assign align_err = align_err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Bench for fetch_mem_unit: directed scenarios plus randomized transactions against a
// transaction-level reference model.
module tb_fetch_mem_unit;

    localparam logic [31:0] RstPc = 32'h0000_0100;
    localparam int unsigned Tmo   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b0, PCWriteCond = 1'b0, Zero = 1'b0;
    logic [1:0]  PCSource = 2'b00;
    logic        IorD = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
    logic [31:0] ALUResult = '0, ALUOut = '0, B = '0;
    logic [31:0] pc, ir, mdr;
    logic [4:0]  Op;
    logic        stall, align_err, bus_err;

    fetch_mem_unit_if bus ();

    fetch_mem_unit #(
        .RESET_PC(RstPc),
        .TIMEOUT (Tmo)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .Zero       (Zero),
        .PCSource   (PCSource),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ALUResult  (ALUResult),
        .ALUOut     (ALUOut),
        .B          (B),
        .mem        (bus.master),
        .pc         (pc),
        .ir         (ir),
        .Op         (Op),
        .mdr        (mdr),
        .stall      (stall),
        .align_err  (align_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_pc, m_ir, m_mdr;
    logic        m_align, m_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_ctrl();
        PCWrite = 0; PCWriteCond = 0; Zero = 0; PCSource = 2'b00;
        IorD = 0; MemRead = 0; MemWrite = 0; IRWrite = 0;
        ALUResult = '0; ALUOut = '0; B = '0;
    endtask

    // Reset is held 2 cycles while a ready read is offered; it must load nothing.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_ctrl();
        MemRead = 1; IRWrite = 1; PCWrite = 1; ALUResult = $urandom;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = $urandom | 32'h1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_ctrl();
        bus.mem_ready = 1'b0;
        m_pc = RstPc; m_ir = '0; m_mdr = '0; m_align = 0; m_bus = 0;
        #1;
        chk("rst_pc", pc, RstPc);
        chk("rst_ir", ir, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_stall", stall, 32'h0);
        chk("rst_align", align_err, 32'h0);
        chk("rst_bus", bus_err, 32'h0);
    endtask

    // One Control state held until the unit releases it; memory answers after lat wait cycles.
    task automatic do_txn(input int lat, input logic [31:0] rdata);
        logic [31:0] addr, npc;
        logic access, misal, req, done, abrt, we;
        int ncyc;
        addr   = IorD ? ALUOut : m_pc;
        access = MemRead | MemWrite;
        misal  = access && (addr % 4 != 0);
        req    = access && !misal && !m_align && !m_bus;
        done   = req && (lat <= int'(Tmo) - 1);
        abrt   = req && !done;
        ncyc   = !req ? 1 : (done ? lat + 1 : int'(Tmo));
        bus.mem_rdata = rdata;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            bus.mem_ready = req ? (i == lat) : 1'($urandom_range(0, 1));
            #1;
            chk("stall", stall, 32'(req && (i < ncyc - 1)));
            chk("mem_rd", bus.mem_rd, 32'(req && MemRead));
            chk("mem_wr", bus.mem_wr, 32'(req && MemWrite && !MemRead));
            chk("pc_hold", pc, m_pc);
            chk("ir_hold", ir, m_ir);
            if (i == 0) begin
                chk("mem_addr", bus.mem_addr, addr);
                chk("mem_wdata", bus.mem_wdata, B);
            end
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        we = (PCWrite || (PCWriteCond && Zero)) && (PCSource != 2'b11) && !abrt;
        case (PCSource)
            2'b00:   npc = ALUResult;
            2'b01:   npc = ALUOut;
            default: npc = (m_pc & 32'hE000_0000) | ((m_ir & 32'h07FF_FFFF) * 4);
        endcase
        if (we) m_pc = npc;
        if (done && MemRead) begin
            m_mdr = rdata;
            if (IRWrite) m_ir = rdata;
        end
        if (misal) m_align = 1;
        if (abrt) m_bus = 1;
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("op", 32'(Op), m_ir >> 27);
        chk("mdr", mdr, m_mdr);
        chk("align_err", align_err, 32'(m_align));
        chk("bus_err", bus_err, 32'(m_bus));
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        do_reset();

        // Zero-wait fetch
        clear_ctrl();
        MemRead = 1; IRWrite = 1; PCWrite = 1; ALUResult = 32'd4;
        do_txn(0, 32'h8C22_0004);
        chk("t2_ir", ir, 32'h8C22_0004);
        chk("t2_op", 32'(Op), 32'h11);
        chk("t2_pc", pc, 32'h4);

        // Three wait cycles
        ALUResult = 32'd8;
        do_txn(3, 32'h0000_0010);
        chk("t3_pc", pc, 32'h8);
        chk("t3_ir", ir, 32'h0000_0010);

        // Branch not taken, then taken
        clear_ctrl();
        PCWriteCond = 1; PCSource = 2'b01; ALUOut = 32'h40; Zero = 0;
        do_txn(0, '0);
        chk("br_nt", pc, 32'h8);
        Zero = 1;
        do_txn(0, '0);
        chk("br_t", pc, 32'h40);

        // Jump from pc=0x2000_0010 with ir[26:0]=0x10
        clear_ctrl();
        MemRead = 1; IRWrite = 1; PCWrite = 1; ALUResult = 32'h2000_0010;
        do_txn(1, 32'h0000_0010);
        clear_ctrl();
        PCWrite = 1; PCSource = 2'b10;
        do_txn(0, '0);
        chk("jump", pc, 32'h2000_0040);

        // Misaligned read
        clear_ctrl();
        MemRead = 1; IorD = 1; ALUOut = 32'h6;
        do_txn(0, 32'hDEAD_BEEF);
        chk("align_set", align_err, 32'h1);

        // Timeout
        do_reset();
        MemRead = 1;
        do_txn(100, 32'h1234_5678);
        chk("bus_set", bus_err, 32'h1);
        chk("bus_stall", stall, 32'h0);
        do_reset();

        for (int t = 0; t < 300; t++) begin
            int lat;
            if ($urandom_range(0, 11) == 0) do_reset();
            MemRead     = ($urandom_range(0, 2) != 0);
            MemWrite    = ($urandom_range(0, 3) == 0);
            IRWrite     = 1'($urandom_range(0, 1));
            PCWrite     = 1'($urandom_range(0, 1));
            PCWriteCond = 1'($urandom_range(0, 1));
            Zero        = 1'($urandom_range(0, 1));
            PCSource    = 2'($urandom_range(0, 3));
            IorD        = 1'($urandom_range(0, 1));
            ALUResult   = $urandom & 32'hFFFF_FFFC;
            ALUOut      = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) ALUOut[1:0] = 2'($urandom_range(1, 3));
            B           = $urandom;
            lat = ($urandom_range(0, 5) == 0) ? int'(Tmo) + 3 : int'($urandom_range(0, Tmo - 1));
            do_txn(lat, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
